linea_retardo: RTL

LINEA_RETARDO -- requirements
Module: linea_retardo

---
 rtl/linea_retardo_pkg.sv | 10 +
 rtl/linea_retardo_if.sv | 33 +++
 rtl/etapa_retardo.sv | 33 +++
 rtl/linea_retardo.sv | 85 ++++++++
 4 files changed

// File: rtl/linea_retardo_pkg.sv
// Shared filter definitions: default sample width and delay-line depth
// used by the delay line and the filter datapath that consumes its taps.
package linea_retardo_pkg;

  localparam int LR_WIDTH_DEF = 22;
  localparam int LR_DEPTH_DEF = 4;
  localparam int LR_DEPTH_MIN = 2;
  localparam int LR_DEPTH_MAX = 16;

endpackage : linea_retardo_pkg

// File: rtl/linea_retardo_if.sv
// Sample-rate bus between the filter control and the delay line: shift
// strobe, flush, new sample and tap select in; stage contents and fill state out.
interface linea_retardo_if
  import linea_retardo_pkg::*;
#(
  parameter int WIDTH = LR_WIDTH_DEF,
  parameter int DEPTH = LR_DEPTH_DEF
);

  localparam int SEL_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   enable;
  logic                   clear;
  logic [WIDTH-1:0]       datoIn;
  logic [SEL_W-1:0]       tapSel;
  logic [WIDTH-1:0]       datoOut;
  logic [DEPTH*WIDTH-1:0] taps;
  logic [WIDTH-1:0]       tapOut;
  logic [CNT_W-1:0]       cuenta;
  logic                   lleno;

  modport master (
    output enable, clear, datoIn, tapSel,
    input  datoOut, taps, tapOut, cuenta, lleno
  );

  modport slave (
    input  enable, clear, datoIn, tapSel,
    output datoOut, taps, tapOut, cuenta, lleno
  );

endinterface : linea_retardo_if

// File: rtl/etapa_retardo.sv
// One delay stage: WIDTH-bit register with load enable, synchronous flush
// and asynchronous active-low reset. Flush wins over load.
module etapa_retardo
  import linea_retardo_pkg::*;
#(
  parameter int WIDTH = LR_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] dato_q;

  // Stage register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dato_q <= '0;
    end else if (clr_i) begin
      dato_q <= '0;
    end else if (en_i) begin
      dato_q <= d_i;
    end else begin
      dato_q <= dato_q;
    end
  end

  assign q_o = dato_q;

endmodule : etapa_retardo

// File: rtl/linea_retardo.sv
// Sample delay line x[n-1]..x[n-DEPTH] with a saturating fill counter and a
// selectable tap read-out; stage k is packed at taps[k*WIDTH +: WIDTH].
module linea_retardo
  import linea_retardo_pkg::*;
#(
  parameter int WIDTH = LR_WIDTH_DEF,
  parameter int DEPTH = LR_DEPTH_DEF
) (
  input  logic           clk44kHz,
  input  logic           reset,
  linea_retardo_if.slave bus
);

  localparam int SEL_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]       etapa_s [DEPTH];
  logic [DEPTH*WIDTH-1:0] taps_s;
  logic [WIDTH-1:0]       tap_out_s;
  logic [CNT_W-1:0]       cuenta_q, cuenta_d;
  logic                   lleno_q, lleno_d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_etapa
    if (k == 0) begin : g_first
      etapa_retardo #(.WIDTH(WIDTH)) u_etapa (
        .clk_i   (clk44kHz),
        .rst_n_i (reset),
        .en_i    (bus.enable),
        .clr_i   (bus.clear),
        .d_i     (bus.datoIn),
        .q_o     (etapa_s[k])
      );
    end else begin : g_next
      etapa_retardo #(.WIDTH(WIDTH)) u_etapa (
        .clk_i   (clk44kHz),
        .rst_n_i (reset),
        .en_i    (bus.enable),
        .clr_i   (bus.clear),
        .d_i     (etapa_s[k-1]),
        .q_o     (etapa_s[k])
      );
    end
  end

  // Pack stages and select the requested tap; out-of-range selects read 0
  always_comb begin
    taps_s    = '0;
    tap_out_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      taps_s[k*WIDTH +: WIDTH] = etapa_s[k];
      tap_out_s = (bus.tapSel == SEL_W'(k)) ? etapa_s[k] : tap_out_s;
    end
  end

  // Next fill count; lleno derives from the next count so both update together
  always_comb begin
    cuenta_d = cuenta_q;
    if (bus.clear) begin
      cuenta_d = '0;
    end else if (bus.enable && (cuenta_q != CNT_W'(DEPTH))) begin
      cuenta_d = cuenta_q + CNT_W'(1);
    end else begin
      cuenta_d = cuenta_q;
    end
    lleno_d = (cuenta_d == CNT_W'(DEPTH));
  end

  // Fill counter and full flag registers
  always_ff @(posedge clk44kHz or negedge reset) begin
    if (!reset) begin
      cuenta_q <= '0;
      lleno_q  <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      lleno_q  <= lleno_d;
    end
  end

  assign bus.datoOut = etapa_s[DEPTH-1];
  assign bus.taps    = taps_s;
  assign bus.tapOut  = tap_out_s;
  assign bus.cuenta  = cuenta_q;
  assign bus.lleno   = lleno_q;

endmodule : linea_retardo
